branch_predictor: RTL and testbench

Tournament branch predictor that answers branch-direction queries from instruction fetch and trains on committed branches reported by the reorder buffer. It holds a local 2-bit-counter table, a global (gshare) 2-bit-counter table and a 2-bit selector table, all indexed by LOCAL_WIDTH address bits. It answers the ROB's `transition_*` port and consumes the ROB's `predictor_*` commit port. The 2-bit selection it returns travels with the branch and comes back at commit.

---
 rtl/branch_predictor.sv | 132 +++++++++++++
 tb/tb_branch_predictor.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// ============================================================================
// branch_predictor
//
// Tournament branch predictor. It holds three tables of 2-bit saturating
// counters, each with 2**LOCAL_WIDTH entries:
//   local    : indexed by the branch address
//   global   : gshare, indexed by address XOR global history register
//   selector : indexed by the branch address; a value >= 2 picks global
// Fetch queries are answered one cycle later. Committed branches from the
// ROB train all three tables and shift the non-speculative GHR.
//
// Ports:
//   clk_in               system clock
//   rst_in               asynchronous active-low reset
//   rdy_in               when low, every register holds and inputs are ignored
//   query_signal         fetch requests a prediction
//   transition_addr      query index (PC[LOCAL_WIDTH+1:2])
//   transition_signal    one-cycle pulse, prediction valid
//   branch               predicted direction (1 = taken)
//   transition_selection {local prediction, global prediction}
//   predictor_signal     ROB commits a branch
//   predictor_branch     actual outcome (1 = taken)
//   predictor_addr       index of the committed branch
//   predictor_selection  {local, global} bits returned with the branch
// ============================================================================
module branch_predictor #(
    parameter int LOCAL_WIDTH = 6
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   query_signal,
    input  logic [LOCAL_WIDTH-1:0] transition_addr,
    output logic                   transition_signal,
    output logic                   branch,
    output logic [1:0]             transition_selection,
    input  logic                   predictor_signal,
    input  logic                   predictor_branch,
    input  logic [LOCAL_WIDTH-1:0] predictor_addr,
    input  logic [1:0]             predictor_selection
);

    localparam int ENTRIES = 1 << LOCAL_WIDTH;

    logic [1:0]             r_local    [ENTRIES];
    logic [1:0]             r_global   [ENTRIES];
    logic [1:0]             r_selector [ENTRIES];
    logic [LOCAL_WIDTH-1:0] r_ghr;

    logic       r_transition_signal;
    logic       r_branch;
    logic [1:0] r_transition_selection;

    logic                   w_query_fire;
    logic                   w_update_fire;
    logic [LOCAL_WIDTH-1:0] w_query_gidx;
    logic [LOCAL_WIDTH-1:0] w_update_gidx;
    logic                   w_query_lp;
    logic                   w_query_gp;
    logic                   w_query_use_global;
    logic                   w_upd_lp;
    logic                   w_upd_gp;

    // Move a 2-bit counter one step toward the outcome, saturating at 0 and 3.
    function automatic logic [1:0] f_move(input logic [1:0] cnt, input logic up);
        logic [1:0] res;
        if (up) begin
            res = (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
        end else begin
            res = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
        end
        return res;
    endfunction

    assign w_query_fire  = query_signal & rdy_in;
    assign w_update_fire = predictor_signal & rdy_in;

    // Both index computations use the GHR as it stands before this edge's
    // shift, so a same-cycle query and update see identical history.
    assign w_query_gidx  = transition_addr ^ r_ghr;
    assign w_update_gidx = predictor_addr ^ r_ghr;

    assign w_query_lp         = r_local[transition_addr][1];
    assign w_query_gp         = r_global[w_query_gidx][1];
    assign w_query_use_global = r_selector[transition_addr][1];

    assign w_upd_lp = predictor_selection[1];
    assign w_upd_gp = predictor_selection[0];

    // Table and history training.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_local[i]    <= 2'b01;
                r_global[i]   <= 2'b01;
                r_selector[i] <= 2'b01;
            end
            r_ghr <= '0;
        end else if (w_update_fire) begin
            r_local[predictor_addr] <= f_move(r_local[predictor_addr], predictor_branch);
            r_global[w_update_gidx] <= f_move(r_global[w_update_gidx], predictor_branch);
            // Selector only learns when the two components disagreed; exactly
            // one of them was right, so step toward global when global was.
            if (w_upd_lp != w_upd_gp) begin
                r_selector[predictor_addr] <= f_move(r_selector[predictor_addr],
                                                     w_upd_gp == predictor_branch);
            end
            r_ghr <= {r_ghr[LOCAL_WIDTH-2:0], predictor_branch};
        end
    end

    // Registered prediction response. Direction and selection hold between
    // queries; the valid pulse clears on any ready cycle without a query.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_transition_signal    <= 1'b0;
            r_branch               <= 1'b0;
            r_transition_selection <= 2'b00;
        end else if (rdy_in) begin
            r_transition_signal <= query_signal;
            if (w_query_fire) begin
                r_transition_selection <= {w_query_lp, w_query_gp};
                r_branch               <= w_query_use_global ? w_query_gp : w_query_lp;
            end
        end
    end

    assign transition_signal    = r_transition_signal;
    assign branch               = r_branch;
    assign transition_selection = r_transition_selection;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam int W = 6;
    localparam int N = 64;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b0;
    logic         rdy_in = 1'b1;
    logic         query_signal = 1'b0;
    logic [W-1:0] transition_addr = '0;
    logic         transition_signal;
    logic         branch;
    logic [1:0]   transition_selection;
    logic         predictor_signal = 1'b0;
    logic         predictor_branch = 1'b0;
    logic [W-1:0] predictor_addr = '0;
    logic [1:0]   predictor_selection = 2'b00;

    int checks = 0;
    int failures = 0;

    // Reference model: plain integer counters and history.
    int   m_loc [N];
    int   m_glob[N];
    int   m_sel [N];
    int   m_ghr;
    logic exp_sig;
    logic exp_br;
    logic [1:0] exp_sel;

    branch_predictor #(.LOCAL_WIDTH(W)) dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .rdy_in               (rdy_in),
        .query_signal         (query_signal),
        .transition_addr      (transition_addr),
        .transition_signal    (transition_signal),
        .branch               (branch),
        .transition_selection (transition_selection),
        .predictor_signal     (predictor_signal),
        .predictor_branch     (predictor_branch),
        .predictor_addr       (predictor_addr),
        .predictor_selection  (predictor_selection)
    );

    always #5 clk_in = ~clk_in;

    function automatic int clamp_step(input int v, input bit up);
        if (up) return (v >= 3) ? 3 : v + 1;
        return (v <= 0) ? 0 : v - 1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_loc[i] = 1; m_glob[i] = 1; m_sel[i] = 1;
        end
        m_ghr = 0; exp_sig = 1'b0; exp_br = 1'b0; exp_sel = 2'b00;
    endfunction

    // Apply one clock edge's worth of behaviour to the model.
    function automatic void model_step();
        int qa, ua, gi; bit lp, gp, s, t;
        if (!rdy_in) return;
        if (query_signal) begin
            qa = int'(transition_addr);
            lp = m_loc[qa] >= 2;
            gp = m_glob[(qa ^ m_ghr) % N] >= 2;
            s  = m_sel[qa] >= 2;
            exp_sel = {lp, gp};
            exp_br  = s ? gp : lp;
        end
        exp_sig = query_signal;
        if (predictor_signal) begin
            ua = int'(predictor_addr);
            t  = predictor_branch;
            gi = (ua ^ m_ghr) % N;
            m_loc[ua]  = clamp_step(m_loc[ua], t);
            m_glob[gi] = clamp_step(m_glob[gi], t);
            if (predictor_selection[1] != predictor_selection[0])
                m_sel[ua] = clamp_step(m_sel[ua], predictor_selection[0] == t);
            m_ghr = ((m_ghr * 2) + int'(t)) % N;
        end
    endfunction

    task automatic tick();
        @(posedge clk_in);
        if (rst_in) model_step();
        #1;
    endtask

    task automatic drive(input bit q, input int qa, input bit u, input int ua,
                         input bit t, input logic [1:0] usel);
        query_signal        = q;
        transition_addr     = W'(qa);
        predictor_signal    = u;
        predictor_addr      = W'(ua);
        predictor_branch    = t;
        predictor_selection = usel;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 2'b00);
        rst_in = 1'b0;
        #2;
        rst_in = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rdy_in = 1'b1;
        drive(1, 5, 0, 0, 0, 2'b00);
        tick();
        checks++;
        if (transition_signal !== 1'b1) begin
            failures++; $display("FAIL pre_reset_sig got=%b want=1", transition_signal);
        end
        #2;
        rst_in = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({transition_signal, branch, transition_selection} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset_outputs got=%b want=0000",
                     {transition_signal, branch, transition_selection});
        end
        tick();
        checks++;
        if ({transition_signal, branch, transition_selection} !== 4'b0000) begin
            failures++;
            $display("FAIL held_reset_outputs got=%b want=0000",
                     {transition_signal, branch, transition_selection});
        end
        #3;
        rst_in = 1'b1;
        tick();
        checks++;
        if (transition_signal !== 1'b1 || branch !== 1'b0 || transition_selection !== 2'b00) begin
            failures++;
            $display("FAIL post_reset_query got sig=%b br=%b sel=%b want sig=1 br=0 sel=00",
                     transition_signal, branch, transition_selection);
        end
        drive(0, 0, 0, 0, 0, 2'b00);
        tick();
        checks++;
        if (transition_signal !== 1'b0) begin
            failures++; $display("FAIL pulse_width got=%b want=0", transition_signal);
        end
        $display("test_reset done");
    endtask

    task automatic test_local_training();
        do_reset();
        drive(0, 0, 1, 3, 1, 2'b00); tick();
        drive(0, 0, 1, 3, 1, 2'b00); tick();
        drive(1, 3, 0, 0, 0, 2'b00); tick();
        checks++;
        if (branch !== exp_br || transition_selection !== exp_sel || branch !== 1'b1 ||
            transition_selection !== 2'b10) begin
            failures++;
            $display("FAIL local_training got br=%b sel=%b want br=1 sel=10 (model br=%b sel=%b)",
                     branch, transition_selection, exp_br, exp_sel);
        end
        $display("test_local_training br=%b sel=%b", branch, transition_selection);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 1, 7, 0, 2'b00); tick();
            drive(1, 7, 0, 0, 0, 2'b00); tick();
            checks++;
            if (transition_selection !== exp_sel || branch !== exp_br ||
                transition_selection[1] !== 1'b0) begin
                failures++;
                $display("FAIL saturation_k%0d got br=%b sel=%b want br=%b sel=%b",
                         k, branch, transition_selection, exp_br, exp_sel);
            end
            $display("test_saturation commit %0d sel=%b", k, transition_selection);
        end
    endtask

    task automatic test_selector();
        do_reset();
        drive(0, 0, 1, 9, 1, 2'b01); tick();
        drive(0, 0, 1, 9, 1, 2'b01); tick();
        drive(1, 9, 0, 0, 0, 2'b00); tick();
        checks++;
        if (branch !== 1'b0 || transition_selection !== 2'b10 ||
            branch !== exp_br || transition_selection !== exp_sel) begin
            failures++;
            $display("FAIL selector_global got br=%b sel=%b want br=0 sel=10",
                     branch, transition_selection);
        end
        $display("test_selector br=%b sel=%b", branch, transition_selection);
    endtask

    task automatic test_collision();
        do_reset();
        drive(1, 2, 1, 2, 1, 2'b00); tick();
        checks++;
        if (branch !== 1'b0 || branch !== exp_br || transition_signal !== 1'b1) begin
            failures++;
            $display("FAIL collision_old got br=%b sig=%b want br=0 sig=1", branch, transition_signal);
        end
        drive(1, 2, 0, 0, 0, 2'b00); tick();
        checks++;
        if (branch !== 1'b1 || branch !== exp_br) begin
            failures++;
            $display("FAIL collision_new got br=%b want br=1", branch);
        end
        $display("test_collision br=%b", branch);
    endtask

    task automatic test_rdy_low();
        logic       save_br;
        logic [1:0] save_sel;
        do_reset();
        drive(0, 0, 1, 4, 1, 2'b01); tick();
        drive(0, 0, 1, 4, 1, 2'b01); tick();
        drive(1, 4, 0, 0, 0, 2'b00); tick();
        save_br = exp_br; save_sel = exp_sel;
        rdy_in = 1'b0;
        drive(1, 11, 1, 4, 0, 2'b10);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (transition_signal !== 1'b1 || branch !== save_br || transition_selection !== save_sel) begin
                failures++;
                $display("FAIL rdy_low_hold_%0d got sig=%b br=%b sel=%b want sig=1 br=%b sel=%b",
                         k, transition_signal, branch, transition_selection, save_br, save_sel);
            end
        end
        rdy_in = 1'b1;
        drive(0, 0, 0, 0, 0, 2'b00); tick();
        checks++;
        if (transition_signal !== 1'b0) begin
            failures++; $display("FAIL rdy_resume_sig got=%b want=0", transition_signal);
        end
        drive(1, 4, 0, 0, 0, 2'b00); tick();
        checks++;
        if (branch !== exp_br || transition_selection !== exp_sel || transition_selection !== 2'b10) begin
            failures++;
            $display("FAIL rdy_low_tables got br=%b sel=%b want br=%b sel=%b",
                     branch, transition_selection, exp_br, exp_sel);
        end
        $display("test_rdy_low br=%b sel=%b", branch, transition_selection);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 30; k++) begin
            drive(0, 0, 1, int'($urandom_range(0, N-1)), bit'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)));
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            drive(1, int'($urandom_range(0, N-1)), 0, 0, 0, 2'b00);
            tick();
            checks++;
            if (transition_signal !== 1'b1 || branch !== exp_br || transition_selection !== exp_sel) begin
                failures++;
                $display("FAIL back_to_back_%0d got sig=%b br=%b sel=%b want sig=1 br=%b sel=%b",
                         k, transition_signal, branch, transition_selection, exp_br, exp_sel);
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int k = 0; k < 500; k++) begin
            rdy_in = ($urandom_range(0, 99) < 85);
            // Small address window to force collisions and counter saturation.
            drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            tick();
            checks++;
            if (transition_signal !== exp_sig || branch !== exp_br || transition_selection !== exp_sel) begin
                failures++; bad++;
                $display("FAIL random_%0d got sig=%b br=%b sel=%b want sig=%b br=%b sel=%b",
                         k, transition_signal, branch, transition_selection, exp_sig, exp_br, exp_sel);
            end
        end
        rdy_in = 1'b1;
        $display("test_random cycles=500 bad=%0d", bad);
    endtask

    initial begin
        model_reset();
        rst_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        test_reset();
        test_local_training();
        test_saturation();
        test_selector();
        test_collision();
        test_rdy_low();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
